// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request-side and engine-side signals of the UART TX arbiter
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int GW = $clog2(NREQ);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic [GW-1:0]     grant_id;
    logic              active;
    logic              err_tmo;
    modport master (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data, grant_id, active, err_tmo
    );
    modport slave (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, active, err_tmo
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART TX engine; UART_ARB_TAG_EN adds a per-burst header byte
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 65535
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, TAG, LOAD, WAIT} state_t;
    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d, rr_q, rr_d, pick, cand;
    logic [7:0]      tx_data_q, tx_data_d, cnt_q, cnt_d;
    logic [15:0]     wd_q, wd_d;
    logic            last_q, last_d, tag_q, tag_d, found, tx_start, err_tmo;
    logic [NREQ-1:0] req_ready;
    logic            sel_valid, sel_last;
    logic [7:0]      sel_data;

    assign sel_valid = bus.req_valid[grant_q];
    assign sel_last  = bus.req_last[grant_q];
    assign sel_data  = bus.req_data[{grant_q, 3'b000} +: 8];

    // Round-robin search: first valid requester after the previous owner, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(rr_q) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Burst sequencing: grant, hand bytes to the engine, wait for tx_done or watchdog
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        last_d    = last_q;
        tag_d     = tag_q;
        req_ready = '0;
        tx_start  = 1'b0;
        err_tmo   = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                rr_d    = pick;
                cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                tx_data_d = 8'hA0 | 8'(pick);
                state_d   = TAG;
`else
                state_d   = LOAD;
`endif
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                tx_start = 1'b1;
                tag_d    = 1'b1;
                last_d   = 1'b0;
                wd_d     = '0;
                state_d  = WAIT;
            end
`endif
            LOAD: if (sel_valid) begin
                req_ready[grant_q] = 1'b1;
                tx_start  = 1'b1;
                tx_data_d = sel_data;
                last_d    = sel_last;
                tag_d     = 1'b0;
                cnt_d     = cnt_q + 8'd1;
                wd_d      = '0;
                state_d   = WAIT;
            end
            WAIT: if (bus.tx_done) begin
                if (!tag_q && (last_q || cnt_q == 8'(MAX_BURST))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = LOAD;
                end
            end else if (wd_q == 16'(TIMEOUT)) begin
                err_tmo = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                wd_d = wd_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; rr starts at NREQ-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= GW'(NREQ - 1);
            tx_data_q <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            last_q    <= 1'b0;
            tag_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            last_q    <= last_d;
            tag_q     <= tag_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.tx_start  = tx_start;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.active    = state_q != IDLE;
    assign bus.err_tmo   = err_tmo;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
    localparam int NREQ = 4, MAXB = 16, TMO = 100;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
    uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );

    int checks = 0, failures = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Client queues, engine controls, logs
    logic [7:0] qd[NREQ][$];
    bit         ql[NREQ][$];
    bit rnd_mode = 0, mute = 0, spur_en = 0, saw_start = 0, prev_start = 0;
    bit [NREQ-1:0] rdy_seen = '0;
    int eng_cnt = 0, cyc = 0, start_cnt = 0, ready_cnt = 0, start_cyc = -1, tmo_cyc = -1;
    int grant_log[$];
    logic [7:0] data_log[$];

    // Model: owner=-1 means no burst; pend means a byte/tag is with the engine
    int m_owner = -1, m_rr = NREQ - 1, m_gid = 0, m_bytes = 0, m_wait = 0;
    bit m_pend = 0, m_end = 0, m_tagdue = 0, m_wastag = 0;
    logic [7:0] m_data = 8'h00;

    // Client driver
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++)
            if (rdy_seen[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        for (int i = 0; i < NREQ; i++) begin
            if (rnd_mode) begin
                bus.req_valid[i]       = $urandom_range(0, 3) != 0;
                bus.req_data[i*8 +: 8] = 8'($urandom);
                bus.req_last[i]        = $urandom_range(0, 3) == 0;
            end else begin
                bus.req_valid[i]       = qd[i].size() > 0;
                bus.req_data[i*8 +: 8] = qd[i].size() > 0 ? qd[i][0] : 8'h00;
                bus.req_last[i]        = ql[i].size() > 0 ? ql[i][0] : 1'b0;
            end
        end
    end

    // Engine: tx_done a fixed or random number of cycles after tx_start
    always @(posedge clk) begin
        #1;
        bus.tx_done = 1'b0;
        if (!rst_n) eng_cnt = 0;
        else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) bus.tx_done = 1'b1;
        end else if (saw_start && !mute) eng_cnt = rnd_mode ? $urandom_range(1, 14) : 9;
        else if (spur_en && !m_pend && $urandom_range(0, 7) == 0) bus.tx_done = 1'b1;
    end

    // Compare process and model update
    always @(negedge clk) begin
        bit e_start, e_tmo;
        logic [NREQ-1:0] e_rdy;
        int c;
        cyc++;
        e_start = 0;
        e_tmo = 0;
        e_rdy = '0;
        if (prev_start && rst_n) data_log.push_back(bus.tx_data);
        if (!rst_n) begin
            m_owner = -1; m_rr = NREQ - 1; m_gid = 0; m_bytes = 0; m_wait = 0;
            m_pend = 0; m_end = 0; m_tagdue = 0; m_wastag = 0; m_data = 8'h00;
        end else begin
            e_start = m_owner >= 0 && !m_pend && (m_tagdue || bus.req_valid[m_owner]);
            if (e_start && !m_tagdue) e_rdy[m_owner] = 1'b1;
            e_tmo = m_pend && !bus.tx_done && m_wait == TMO;
        end
        check("tx_start", bus.tx_start, e_start);
        check("req_ready", bus.req_ready, e_rdy);
        check("err_tmo", bus.err_tmo, e_tmo);
        check("active", bus.active, m_owner >= 0);
        check("grant_id", bus.grant_id, m_gid);
        check("tx_data", bus.tx_data, m_data);
        if (bus.tx_start) begin
            start_cnt++;
            start_cyc = cyc;
            grant_log.push_back(int'(bus.grant_id));
        end
        if (bus.err_tmo) tmo_cyc = cyc;
        ready_cnt += $countones(bus.req_ready);
        saw_start  = bus.tx_start;
        prev_start = bus.tx_start;
        rdy_seen   = bus.req_ready;
        if (rst_n) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_rr + k) % NREQ;
                    if (m_owner < 0 && bus.req_valid[c]) m_owner = c;
                end
                if (m_owner >= 0) begin
                    m_rr = m_owner;
                    m_gid = m_owner;
                    m_bytes = 0;
`ifdef UART_ARB_TAG_EN
                    m_tagdue = 1;
                    m_data = 8'hA0 | 8'(m_owner);
`endif
                end
            end else if (!m_pend) begin
                if (e_start) begin
                    m_pend = 1;
                    m_wait = 0;
                    m_wastag = m_tagdue;
                    if (m_tagdue) m_tagdue = 0;
                    else begin
                        m_bytes++;
                        m_end = bus.req_last[m_owner];
                        m_data = bus.req_data[m_owner*8 +: 8];
                    end
                end
            end else if (bus.tx_done) begin
                m_pend = 0;
                if (!m_wastag && (m_end || m_bytes == MAXB)) m_owner = -1;
            end else if (m_wait == TMO) begin
                m_pend = 0;
                m_owner = -1;
            end else m_wait++;
        end
    end

    function automatic bit qbusy();
        for (int i = 0; i < NREQ; i++) if (qd[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input bit l);
        qd[r].push_back(d);
        ql[r].push_back(l);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        data_log.delete();
        ready_cnt = 0;
        start_cnt = 0;
        start_cyc = -1;
        tmo_cyc = -1;
    endtask

    task automatic wait_quiet(input string name, input bit need_free);
        int n = 0;
        while ((qbusy() || m_pend || (need_free && m_owner >= 0)) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check(name, n < 2000, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic cmp_logs(input string name, input int eg[$], input logic [7:0] ed[$]);
        check({name, "_ngrant"}, grant_log.size(), eg.size());
        check({name, "_ndata"}, data_log.size(), ed.size());
        for (int i = 0; i < eg.size() && i < grant_log.size(); i++) check({name, "_grant"}, grant_log[i], eg[i]);
        for (int i = 0; i < ed.size() && i < data_log.size(); i++) check({name, "_data"}, data_log[i], ed[i]);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        int eg[$];
        logic [7:0] ed[$];
        int n;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.tx_done = 1'b0;
        #1;
        check("rst_active", bus.active, 0);
        check("rst_tx_start", bus.tx_start, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // Idle after reset release
        repeat (100) @(posedge clk);
        #2;
        check("t1_starts", start_cnt, 0);
        check("t1_tx_data", bus.tx_data, 8'h00);
        check("t1_grant_id", bus.grant_id, 0);
`ifndef UART_ARB_TAG_EN
        // Two 2-byte bursts on requesters 0 and 2
        clear_logs();
        push(0, 8'h11, 0); push(0, 8'h12, 1);
        push(2, 8'h21, 0); push(2, 8'h22, 1);
        wait_quiet("t2_done", 1);
        eg = '{0, 0, 2, 2};
        ed = '{8'h11, 8'h12, 8'h21, 8'h22};
        cmp_logs("t2", eg, ed);
        check("t2_ready", ready_cnt, 4);
        // MAX_BURST rotation: requester 1 streams 20 bytes, requester 3 gets in between
        reset_dut();
        eg.delete();
        ed.delete();
        for (int i = 0; i < 20; i++) push(1, 8'h30 + 8'(i), 0);
        push(3, 8'h77, 1);
        for (int i = 0; i < 16; i++) begin eg.push_back(1); ed.push_back(8'h30 + 8'(i)); end
        eg.push_back(3); ed.push_back(8'h77);
        for (int i = 16; i < 20; i++) begin eg.push_back(1); ed.push_back(8'h30 + 8'(i)); end
        wait_quiet("t3_done", 0);
        cmp_logs("t3", eg, ed);
        // Watchdog: engine silent
        reset_dut();
        mute = 1;
        push(0, 8'hC3, 1);
        n = 0;
        while (tmo_cyc < 0 && n < 400) begin @(posedge clk); n++; end
        check("t4_tmo_seen", tmo_cyc >= 0, 1);
        check("t4_tmo_delay", tmo_cyc - start_cyc, 101);
        repeat (2) @(posedge clk);
        #2;
        check("t4_active_off", bus.active, 0);
        mute = 0;
        clear_logs();
        push(2, 8'h5A, 1);
        wait_quiet("t4_done", 1);
        eg = '{2};
        ed = '{8'h5A};
        cmp_logs("t4", eg, ed);
        // Reset during WAIT
        push(1, 8'h01, 0); push(1, 8'h02, 0); push(1, 8'h03, 1);
        n = 0;
        while (!m_pend && n < 50) begin @(posedge clk); n++; end
        check("t5_in_wait", m_pend, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_active", bus.active, 0);
        check("t5_tx_start", bus.tx_start, 0);
        check("t5_req_ready", bus.req_ready, 0);
        for (int i = 0; i < NREQ; i++) begin qd[i].delete(); ql[i].delete(); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_logs();
        push(1, 8'hB1, 1);
        push(0, 8'hB0, 1);
        wait_quiet("t5_done", 1);
        eg = '{0, 1};
        ed = '{8'hB0, 8'hB1};
        cmp_logs("t5", eg, ed);
`else
        // Tag header before a single byte
        reset_dut();
        push(2, 8'h55, 1);
        wait_quiet("t6_done", 1);
        eg = '{2, 2};
        ed = '{8'hA2, 8'h55};
        cmp_logs("t6", eg, ed);
        check("t6_ready", ready_cnt, 1);
`endif
        // Random traffic with random engine latency, stray tx_done and a mid-run reset
        reset_dut();
        rnd_mode = 1;
        spur_en = 1;
        repeat (1500) @(posedge clk);
        reset_dut();
        repeat (1500) @(posedge clk);
        #2;
        check("rnd_progress", start_cnt > 100, 1);
        rnd_mode = 0;
        spur_en = 0;
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
